// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetch stage. Reads opcode and up to two operand
// bytes from byte-wide program memory over a req/ack bus, presents one
// assembled bundle to the execute unit over valid/ready, and restarts at a
// new address on redirect. Every output is registered.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h00A0,
    parameter logic [7:0]  HLT_OPC  = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [7:0]  ir,
    output logic [7:0]  op1,
    output logic [7:0]  op2,
    output logic [1:0]  ilen,
    output logic [15:0] ipc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        F_OPC  = 3'd0,
        F_OP1  = 3'd1,
        F_OP2  = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_fetch_pc;
    logic [1:0]  w_len;
    logic        w_accept;

    // Instruction length from the opcode byte; unknown opcodes are single-byte.
    function automatic logic [1:0] len_decode(input logic [7:0] opc);
        logic [1:0] len;
        len = 2'd1;
        if (opc == 8'hA2 || opc == 8'hA6 || opc == 8'hF0 || opc == 8'hD0)
            len = 2'd2;
        else if (opc == 8'h4C)
            len = 2'd3;
        if (opc == 8'hE8 || opc == 8'hCA || opc == HLT_OPC)
            len = 2'd1;
        return len;
    endfunction

    assign w_len    = len_decode(mem_rdata);
    assign w_accept = ir_valid && ir_ready;

    // Fetch sequencer: request/ack beats, bundle hand-off, redirect and halt.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= F_OPC;
            r_fetch_pc  <= RESET_PC;
            mem_rd      <= 1'b0;
            mem_addr    <= 16'h0000;
            ir_valid    <= 1'b0;
            ir          <= 8'h00;
            op1         <= 8'h00;
            op2         <= 8'h00;
            ilen        <= 2'd0;
            ipc         <= 16'h0000;
            instr_count <= 16'h0000;
        end else begin
            // A bundle taken in the same cycle as a redirect still counts.
            if (w_accept)
                instr_count <= instr_count + 16'd1;

            if (redirect) begin
                // Abandon whatever is in flight, including an ack this cycle.
                r_state    <= F_OPC;
                r_fetch_pc <= redirect_pc;
                mem_rd     <= 1'b1;
                mem_addr   <= redirect_pc;
                ir_valid   <= 1'b0;
            end else begin
                case (r_state)
                    F_OPC: begin
                        if (!mem_rd) begin
                            // First request after reset leaves the bus idle one cycle.
                            mem_rd   <= 1'b1;
                            mem_addr <= r_fetch_pc;
                        end else if (mem_ack) begin
                            ir   <= mem_rdata;
                            ipc  <= r_fetch_pc;
                            ilen <= w_len;
                            op1  <= 8'h00;
                            op2  <= 8'h00;
                            if (w_len > 2'd1) begin
                                r_state  <= F_OP1;
                                mem_addr <= r_fetch_pc + 16'd1;
                            end else begin
                                r_state  <= HOLD;
                                mem_rd   <= 1'b0;
                                ir_valid <= 1'b1;
                            end
                        end
                    end
                    F_OP1: begin
                        if (mem_ack) begin
                            op1 <= mem_rdata;
                            if (ilen == 2'd3) begin
                                r_state  <= F_OP2;
                                mem_addr <= ipc + 16'd2;
                            end else begin
                                r_state  <= HOLD;
                                mem_rd   <= 1'b0;
                                ir_valid <= 1'b1;
                            end
                        end
                    end
                    F_OP2: begin
                        if (mem_ack) begin
                            op2      <= mem_rdata;
                            r_state  <= HOLD;
                            mem_rd   <= 1'b0;
                            ir_valid <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (ir_ready) begin
                            ir_valid   <= 1'b0;
                            r_fetch_pc <= ipc + {14'd0, ilen};
                            if (ir == HLT_OPC) begin
                                r_state <= HALTED;
                            end else begin
                                r_state  <= F_OPC;
                                mem_rd   <= 1'b1;
                                mem_addr <= ipc + {14'd0, ilen};
                            end
                        end
                    end
                    HALTED: begin
                        mem_rd   <= 1'b0;
                        ir_valid <= 1'b0;
                    end
                    default: begin
                        r_state <= F_OPC;
                        mem_rd  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed sequences, an opcode table and a randomized run
// against a memory-walking reference model for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [7:0]  ir;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [1:0]  ilen;
    logic [15:0] ipc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr_count;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir_ready(ir_ready),
        .ir(ir), .op1(op1), .op2(op2), .ilen(ilen), .ipc(ipc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Program memory and its response knobs.
    logic [7:0]  mem [0:65535];
    int          wait_n = 0;
    bit          rand_ack = 1'b0;
    int          wcnt = 0;
    logic        prev_rd = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_addr = 16'h0;

    // Protocol monitors.
    logic        p_hold = 1'b0;
    logic [41:0] p_bundle = '0;
    logic        p_wait = 1'b0;
    logic [15:0] p_waddr = 16'h0;

    // Reference model state.
    bit          sb_en = 1'b0;
    logic [15:0] sb_pc = 16'h0;
    int          sb_cnt = 0;

    function automatic int ref_len(input logic [7:0] opc);
        logic [7:0] two [4] = '{8'hA2, 8'hA6, 8'hF0, 8'hD0};
        if (opc == 8'h4C) return 3;
        foreach (two[k]) if (opc == two[k]) return 2;
        return 1;
    endfunction

    // Expected bundle {ir,op1,op2,ilen,ipc} for an instruction starting at pc.
    function automatic logic [41:0] ref_bundle(input logic [15:0] pc);
        int         n;
        logic [7:0] b1, b2;
        n  = ref_len(mem[pc]);
        b1 = (n > 1) ? mem[pc + 16'd1] : 8'h00;
        b2 = (n > 2) ? mem[pc + 16'd2] : 8'h00;
        return {mem[pc], b1, b2, 2'(n), pc};
    endfunction

    // Memory responder, protocol monitors and scoreboard; all act on the
    // values the DUT will see at the next rising edge.
    always @(negedge clk) begin
        logic ack;
        if (mem_rd && prev_rd && mem_addr == prev_addr && !prev_ack) wcnt = wcnt + 1;
        else wcnt = 0;
        if (rand_ack) ack = mem_rd && ($urandom_range(0, 2) != 0);
        else          ack = mem_rd && (wcnt >= wait_n);
        mem_ack   = ack;
        mem_rdata = ack ? mem[mem_addr] : 8'($urandom);
        prev_rd   = mem_rd;
        prev_addr = mem_addr;
        prev_ack  = ack;

        if (p_hold) chk("hold_stable", {ir_valid, ir, op1, op2, ilen, ipc}, {1'b1, p_bundle});
        if (p_wait) chk("addr_stable", {mem_rd, mem_addr}, {1'b1, p_waddr});
        p_hold   = rst && ir_valid && !ir_ready && !redirect;
        p_bundle = {ir, op1, op2, ilen, ipc};
        p_wait   = rst && mem_rd && !ack && !redirect;
        p_waddr  = mem_addr;

        if (sb_en && rst) begin
            if (ir_valid && ir_ready) begin
                chk("sb_bundle", {ir, op1, op2, ilen, ipc}, ref_bundle(sb_pc));
                sb_pc  = sb_pc + 16'(ref_len(mem[sb_pc]));
                sb_cnt = sb_cnt + 1;
            end
            if (redirect) sb_pc = redirect_pc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ir_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({nm, "_timeout"}, ir_valid, 1);
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [7:0] e_ir, e_op1, e_op2;
        logic [1:0] e_len;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic [15:0] base;

        vecs[0] = '{8'hE8, 8'h12, 8'h34, 8'hE8, 8'h00, 8'h00, 2'd1};
        vecs[1] = '{8'hCA, 8'h12, 8'h34, 8'hCA, 8'h00, 8'h00, 2'd1};
        vecs[2] = '{8'h02, 8'h12, 8'h34, 8'h02, 8'h00, 8'h00, 2'd1};
        vecs[3] = '{8'hA2, 8'h11, 8'h22, 8'hA2, 8'h11, 8'h00, 2'd2};
        vecs[4] = '{8'hA6, 8'h33, 8'h44, 8'hA6, 8'h33, 8'h00, 2'd2};
        vecs[5] = '{8'hF0, 8'h55, 8'h66, 8'hF0, 8'h55, 8'h00, 2'd2};
        vecs[6] = '{8'hD0, 8'h77, 8'h88, 8'hD0, 8'h77, 8'h00, 2'd2};
        vecs[7] = '{8'h4C, 8'h99, 8'hAA, 8'h4C, 8'h99, 8'hAA, 2'd3};
        vecs[8] = '{8'h00, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 2'd1};
        vecs[9] = '{8'hFF, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h00, 2'd1};

        rst = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'hEA;
        mem[16'h00A0] = 8'hE8; mem[16'h00A1] = 8'hCA; mem[16'h00A2] = 8'h02;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_outputs", {mem_rd, mem_addr, ir_valid, ir, op1, op2, ilen, ipc, instr_count}, '0);

        // Two single-byte bundles then HLT, zero-wait memory, CPU always ready
        step(); rst = 1'b1; ir_ready = 1'b1;
        @(negedge clk); chk("first_rd_not_yet", mem_rd, 0);
        @(negedge clk); chk("first_rd", {mem_rd, mem_addr}, {1'b1, 16'h00A0});
        @(negedge clk); chk("b0_E8", {ir_valid, ir, op1, op2, ilen, ipc}, {1'b1, 8'hE8, 16'h0, 2'd1, 16'h00A0});
        @(negedge clk); chk("after_acc0", {ir_valid, mem_rd, mem_addr, instr_count}, {2'b01, 16'h00A1, 16'd1});
        @(negedge clk); chk("b1_CA", {ir_valid, ir, op1, op2, ilen, ipc}, {1'b1, 8'hCA, 16'h0, 2'd1, 16'h00A1});
        @(negedge clk); chk("after_acc1", {mem_rd, mem_addr, instr_count}, {1'b1, 16'h00A2, 16'd2});
        @(negedge clk); chk("b2_HLT", {ir_valid, ir, ilen, ipc}, {1'b1, 8'h02, 2'd1, 16'h00A2});
        @(negedge clk); chk("halted_entry", {ir_valid, mem_rd, instr_count}, {2'b00, 16'd3});
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen = seen | mem_rd | ir_valid; end
        chk("halted_idle", seen, 0);

        // Redirect out of HALTED into a 3-byte instruction with 2-cycle waits
        mem[16'h00A0] = 8'h4C; mem[16'h00A1] = 8'h10; mem[16'h00A2] = 8'h01;
        mem[16'h00A3] = 8'hA2; mem[16'h00A4] = 8'h05;
        mem[16'h00A5] = 8'hA6; mem[16'h00A6] = 8'h33; mem[16'h0120] = 8'hE8;
        wait_n = 2; ir_ready = 1'b0;
        step(); redirect = 1'b1; redirect_pc = 16'h00A0;
        step(); redirect = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("wait_addr", {ir_valid, mem_rd, mem_addr}, {2'b01, 16'h00A0 + 16'(i / 3)});
        end
        @(negedge clk); chk("b_4C", {ir_valid, ir, op1, op2, ilen, ipc}, {1'b1, 8'h4C, 8'h10, 8'h01, 2'd3, 16'h00A0});

        // Stall with ir_ready low on a 2-byte instruction
        wait_n = 0;
        step(); ir_ready = 1'b1;
        step(); ir_ready = 1'b0;
        wait_valid("b_A2");
        chk("b_A2", {ir, op1, op2, ilen, ipc, instr_count}, {8'hA2, 8'h05, 8'h00, 2'd2, 16'h00A3, 16'd4});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall", {ir_valid, mem_rd, ir, op1, ipc, instr_count}, {2'b10, 8'hA2, 8'h05, 16'h00A3, 16'd4});
        end

        // Redirect during F_OP1 while the operand is being acked
        step(); ir_ready = 1'b1;
        step(); ir_ready = 1'b0;
        step(); redirect = 1'b1; redirect_pc = 16'h0120;
        @(negedge clk); chk("in_op1", {mem_rd, mem_addr, instr_count}, {1'b1, 16'h00A6, 16'd5});
        step(); redirect = 1'b0;
        @(negedge clk); chk("redir_addr", {ir_valid, mem_rd, mem_addr}, {2'b01, 16'h0120});
        @(negedge clk); chk("redir_bundle", {ir_valid, ir, op1, op2, ilen, ipc}, {1'b1, 8'hE8, 16'h0, 2'd1, 16'h0120});

        // Operand fetch wraps FFFF -> 0000
        mem[16'hFFFF] = 8'hA6; mem[16'h0000] = 8'h07; mem[16'h0001] = 8'h02;
        step(); redirect = 1'b1; redirect_pc = 16'hFFFF;
        step(); redirect = 1'b0;
        wait_valid("b_wrap");
        chk("b_wrap", {ir, op1, op2, ilen, ipc, instr_count}, {8'hA6, 8'h07, 8'h00, 2'd2, 16'hFFFF, 16'd5});
        step(); ir_ready = 1'b1;
        step(); ir_ready = 1'b0;
        @(negedge clk); chk("wrap_next_pc", {mem_rd, mem_addr, instr_count}, {1'b1, 16'h0001, 16'd6});
        wait_valid("b_hlt2");
        chk("b_hlt2", {ir, ilen, ipc}, {8'h02, 2'd1, 16'h0001});
        step(); ir_ready = 1'b1;
        step(); ir_ready = 1'b0;

        // Reset during F_OP2
        mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h11; mem[16'h0202] = 8'h22;
        step(); redirect = 1'b1; redirect_pc = 16'h0200;
        step(); redirect = 1'b0;
        step();
        step(); rst = 1'b0;
        @(negedge clk); chk("in_op2", {mem_rd, mem_addr, instr_count}, {1'b1, 16'h0202, 16'd7});
        @(negedge clk);
        chk("rst_mid", {mem_rd, mem_addr, ir_valid, ir, op1, op2, ilen, ipc, instr_count}, '0);
        step(); rst = 1'b1;

        // Opcode table
        for (int i = 0; i < 10; i++) begin
            base = 16'h0400 + 16'(i * 8);
            mem[base] = vecs[i].b0; mem[base + 16'd1] = vecs[i].b1; mem[base + 16'd2] = vecs[i].b2;
            step(); redirect = 1'b1; redirect_pc = base; ir_ready = 1'b1;
            step(); redirect = 1'b0;
            wait_valid("tbl");
            chk($sformatf("tbl_%0d", i), {ir, op1, op2, ilen, ipc},
                {vecs[i].e_ir, vecs[i].e_op1, vecs[i].e_op2, vecs[i].e_len, base});
        end

        // Randomized run: random ack, ready and redirects against the model
        ir_ready = 1'b0;
        step(); rst = 1'b0;
        step();
        for (int a = 16'h1000; a < 16'h2000; a++) begin
            mem[a] = 8'($urandom);
            if (mem[a] == 8'h02) mem[a] = 8'h4C;
        end
        sb_en = 1'b1; rand_ack = 1'b1; sb_cnt = 0;
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h1000 + 16'($urandom_range(0, 16'h0F00));
        for (int c = 0; c < 1500; c++) begin
            step();
            ir_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 39) == 0);
            redirect_pc = 16'h1000 + 16'($urandom_range(0, 16'h0F00));
        end
        redirect = 1'b0; ir_ready = 1'b0;
        step();
        @(negedge clk);
        chk("sb_count", instr_count, 16'(sb_cnt));
        chk("sb_progress", sb_cnt > 50, 1);
        sb_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
